// File: rtl/sorcerer_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sorcerer_ram_arbiter_if
// Signal bundle between the Sorcerer core / download stream / memory
// controller (master side) and the RAM arbiter (slave side).
//   cpu_*  : Z80 request strobe, captured command, completion and status
//   dl_*   : download write stream and its FIFO status
//   mem_*  : single external RAM port
//   dbg_state : arbiter FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
// ---------------------------------------------------------------------------
interface sorcerer_ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic        cpu_overrun;

  logic        dl_we;
  logic [14:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_full;
  logic        dl_idle;

  logic        mem_cs;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  logic [1:0]  dbg_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait, cpu_overrun,
    input  dl_we, dl_addr, dl_data,
    output dl_full, dl_idle,
    output mem_cs, mem_we, mem_addr, mem_d,
    input  mem_q,
    output dbg_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait, cpu_overrun,
    output dl_we, dl_addr, dl_data,
    input  dl_full, dl_idle,
    input  mem_cs, mem_we, mem_addr, mem_d,
    output mem_q,
    input  dbg_state
  );
endinterface

// File: rtl/sorcerer_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sorcerer_ram_arbiter
// Shares the single 32K external RAM port between the Z80 and the download
// (DL) write stream. DL writes are buffered in a small FIFO; the CPU has
// priority, but after MAX_CPU_RUN consecutive CPU grants with DL data
// waiting, one DL write is forced through.
//
// Ports:
//   CLK12 : system clock
//   RESET : synchronous active-high reset; aborts any access, flushes FIFO
//   bus   : sorcerer_ram_arbiter_if.slave (cpu_*, dl_*, mem_*, dbg_state)
//
// Handshake semantics:
//   cpu_req is a one-cycle strobe; {cpu_we, cpu_addr, cpu_wdata} are taken
//   in that cycle. cpu_wait is high from the cpu_req cycle through the
//   cpu_ack cycle inclusive; cpu_ack pulses for one cycle and cpu_rdata is
//   valid with it for reads. A cpu_req while one is outstanding is dropped
//   and sets the sticky cpu_overrun. dl_we is accepted in any cycle where
//   dl_full is low and dropped otherwise; DL writes get no ack, dl_idle
//   reports that all accepted DL writes have been issued. mem_cs is a
//   one-cycle strobe qualifying mem_we/mem_addr/mem_d; read data is taken
//   from mem_q LATENCY cycles after mem_cs.
// ---------------------------------------------------------------------------
module sorcerer_ram_arbiter #(
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_CPU_RUN = 3
) (
  input logic                   CLK12,
  input logic                   RESET,
  sorcerer_ram_arbiter_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_CPU_RUN);
  localparam logic [2:0]    LAT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;

  // Pending CPU command; stays set through service until the DONE cycle.
  logic          pend_q, pend_d;
  logic          pend_we_q, pend_we_d;
  logic [14:0]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_wdata_q, pend_wdata_d;

  // Granted access, held from the grant until the next grant.
  logic          gnt_cpu_q, gnt_cpu_d;
  logic          gnt_we_q, gnt_we_d;
  logic [14:0]   gnt_addr_q, gnt_addr_d;
  logic [7:0]    gnt_data_q, gnt_data_d;

  logic [2:0]    lat_q, lat_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ovr_q, ovr_d;
  logic [RW-1:0] run_q, run_d;

  // DL FIFO: {addr, data} entries, occupancy counter with one extra bit.
  logic [22:0]   fifo_q [FIFO_DEPTH];
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          cpu_accept;
  logic          cpu_elig;
  logic          eff_we;
  logic [14:0]   eff_addr;
  logic [7:0]    eff_wdata;
  logic [22:0]   head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign push       = bus.dl_we & ~fifo_full;
  assign head       = fifo_q[rd_ptr_q];

  // A new request is only taken when nothing is outstanding.
  assign cpu_accept = bus.cpu_req & ~pend_q;
  assign cpu_elig   = pend_q | cpu_accept;

  // Pending-bypass: a request arriving in an IDLE cycle is granted from the
  // live inputs instead of waiting a cycle for the pending register.
  assign eff_we    = pend_q ? pend_we_q    : bus.cpu_we;
  assign eff_addr  = pend_q ? pend_addr_q  : bus.cpu_addr;
  assign eff_wdata = pend_q ? pend_wdata_q : bus.cpu_wdata;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    gnt_cpu_d    = gnt_cpu_q;
    gnt_we_d     = gnt_we_q;
    gnt_addr_d   = gnt_addr_q;
    gnt_data_d   = gnt_data_q;
    lat_d        = lat_q;
    rdata_d      = rdata_q;
    ovr_d        = ovr_q | (bus.cpu_req & pend_q);
    run_d        = run_q;
    pop          = 1'b0;

    if (cpu_accept) begin
      pend_d       = 1'b1;
      pend_we_d    = bus.cpu_we;
      pend_addr_d  = bus.cpu_addr;
      pend_wdata_d = bus.cpu_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_elig && (fifo_empty || (run_q < RUN_MAX))) begin
          state_d    = S_ISSUE;
          gnt_cpu_d  = 1'b1;
          gnt_we_d   = eff_we;
          gnt_addr_d = eff_addr;
          gnt_data_d = eff_wdata;
          // The run only counts while DL data is actually being held off.
          run_d      = fifo_empty ? '0 : run_q + RW'(1);
        end else if (!fifo_empty) begin
          state_d    = S_ISSUE;
          pop        = 1'b1;
          gnt_cpu_d  = 1'b0;
          gnt_we_d   = 1'b1;
          gnt_addr_d = head[22:8];
          gnt_data_d = head[7:0];
          run_d      = '0;
        end else begin
          run_d      = '0;
        end
      end
      S_ISSUE: begin
        if (gnt_we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 3'd0) begin
          if (gnt_cpu_q) rdata_d = bus.mem_q;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_DONE: begin
        if (gnt_cpu_q) pend_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && fifo_empty) run_d = '0;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK12) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      gnt_cpu_q    <= 1'b0;
      gnt_we_q     <= 1'b0;
      gnt_addr_q   <= '0;
      gnt_data_q   <= '0;
      lat_q        <= '0;
      rdata_q      <= '0;
      ovr_q        <= 1'b0;
      run_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      gnt_cpu_q    <= gnt_cpu_d;
      gnt_we_q     <= gnt_we_d;
      gnt_addr_q   <= gnt_addr_d;
      gnt_data_q   <= gnt_data_d;
      lat_q        <= lat_d;
      rdata_q      <= rdata_d;
      ovr_q        <= ovr_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and counter define what is valid.
  always_ff @(posedge CLK12) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.dl_addr, bus.dl_data};
  end

  assign bus.mem_cs      = (state_q == S_ISSUE);
  assign bus.mem_we      = gnt_we_q;
  assign bus.mem_addr    = gnt_addr_q;
  assign bus.mem_d       = gnt_data_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_ack     = (state_q == S_DONE) & gnt_cpu_q;
  assign bus.cpu_wait    = ~RESET & (bus.cpu_req | pend_q);
  assign bus.cpu_overrun = ovr_q;
  assign bus.dl_full     = fifo_full;
  assign bus.dl_idle     = fifo_empty & ~((state_q != S_IDLE) & ~gnt_cpu_q);
  assign bus.dbg_state   = state_q;

endmodule
